// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Show-ahead receive FIFO for a UART, with parity-error handling
//            and saturating overflow / error statistics.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH           = 16,
  parameter int UART_DATA_WIDTH = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic [UART_DATA_WIDTH:0]     din,
  input  logic                         drop_err,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [UART_DATA_WIDTH-1:0]   dout,
  output logic                         dout_err,
  input  logic                         flush,
  input  logic                         clear_stats,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         ovf_cnt,
  output logic [CNT_WIDTH-1:0]         err_cnt
);

  localparam int c_addr_w = $clog2(DEPTH);

  logic [UART_DATA_WIDTH:0] r_mem [DEPTH];
  logic [c_addr_w:0]        r_wr_ptr;
  logic [c_addr_w:0]        r_rd_ptr;
  logic                     r_overflow;
  logic [CNT_WIDTH-1:0]     r_ovf_cnt;
  logic [CNT_WIDTH-1:0]     r_err_cnt;

  logic w_hs;
  logic w_flag;
  logic w_discard;
  logic w_pop;
  logic w_push;
  logic w_ovf;
  logic w_full;
  logic w_empty;

  // The receiver is never back-pressured; only reset holds it off.
  assign din_ready = reset;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

  assign w_hs      = din_valid & din_ready;
  assign w_flag    = din[UART_DATA_WIDTH];
  assign w_discard = w_flag & drop_err;
  assign w_pop     = dout_valid & dout_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push    = w_hs & ~w_discard & (~w_full | w_pop);
  assign w_ovf     = w_hs & ~w_discard & w_full & ~w_pop;

  assign level      = r_wr_ptr - r_rd_ptr;
  assign full       = w_full;
  assign empty      = w_empty;
  assign dout_valid = ~w_empty;
  assign dout       = r_mem[r_rd_ptr[c_addr_w-1:0]][UART_DATA_WIDTH-1:0];
  assign dout_err   = r_mem[r_rd_ptr[c_addr_w-1:0]][UART_DATA_WIDTH];
  assign overflow   = r_overflow;
  assign ovf_cnt    = r_ovf_cnt;
  assign err_cnt    = r_err_cnt;

  always_ff @(posedge clock) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Statistics ignore flush; clear_stats overrides any same-cycle event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_ovf_cnt  <= '0;
      r_err_cnt  <= '0;
    end else if (clear_stats) begin
      r_overflow <= 1'b0;
      r_ovf_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_ovf) begin
        r_overflow <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
      if (w_hs && w_flag && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       din_valid;
  logic       din_ready;
  logic [8:0] din;
  logic       drop_err;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout;
  logic       dout_err;
  logic       flush;
  logic       clear_stats;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] ovf_cnt;
  logic [7:0] err_cnt;

  int n_total = 0;
  int n_bad   = 0;

  uart_rx_fifo #(.DEPTH(16), .UART_DATA_WIDTH(8), .CNT_WIDTH(8)) u_dut (
    .clock(clock), .reset(reset),
    .din_valid(din_valid), .din_ready(din_ready), .din(din), .drop_err(drop_err),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .dout_err(dout_err),
    .flush(flush), .clear_stats(clear_stats), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .ovf_cnt(ovf_cnt), .err_cnt(err_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_ch(input logic flag, input logic [7:0] d);
    din_valid = 1'b1;
    din       = {flag, d};
    step();
    din_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] nxt;
    int pushed, popped, cyc;

    reset = 1'b0; din_valid = 1'b0; din = '0; drop_err = 1'b0;
    dout_ready = 1'b0; flush = 1'b0; clear_stats = 1'b0;
    step(); step();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_din_ready", din_ready, 0);
    reset = 1'b1;
    #1;
    chk("din_ready_up", din_ready, 1);

    // Three characters, then drain in order.
    push_ch(1'b0, 8'h41);
    chk("latency_valid", dout_valid, 1);
    chk("latency_data", dout, 8'h41);
    push_ch(1'b0, 8'h42);
    push_ch(1'b0, 8'h43);
    chk("level3", level, 3);
    dout_ready = 1'b1;
    chk("pop0", dout, 8'h41);
    step();
    chk("pop1", dout, 8'h42);
    step();
    chk("pop2", dout, 8'h43);
    step();
    dout_ready = 1'b0;
    chk("drained_empty", empty, 1);

    // Overfill by one, then a same-cycle push/pop at full.
    for (int i = 0; i < 17; i++) push_ch(1'b0, 8'h10 + 8'(i));
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt1", ovf_cnt, 1);
    chk("ovf_head", dout, 8'h10);
    din_valid = 1'b1; din = {1'b0, 8'h99}; dout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    chk("pp_level", level, 16);
    chk("pp_ovf_cnt", ovf_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", dout, (i < 15) ? 8'h11 + 8'(i) : 8'h99);
      step();
    end
    dout_ready = 1'b0;
    chk("ovf_drained", empty, 1);

    // Parity-error handling.
    drop_err = 1'b1;
    push_ch(1'b1, 8'h55);
    chk("perr_drop_cnt", err_cnt, 1);
    chk("perr_drop_level", level, 0);
    drop_err = 1'b0;
    push_ch(1'b1, 8'h55);
    chk("perr_keep_cnt", err_cnt, 2);
    chk("perr_keep_data", dout, 8'h55);
    chk("perr_keep_flag", dout_err, 1);
    chk("perr_keep_level", level, 1);
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;

    // Bring ovf_cnt to 3, clear it, then clear against a coincident overflow.
    for (int i = 0; i < 18; i++) push_ch(1'b0, 8'(i));
    chk("ovf_cnt3", ovf_cnt, 3);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("clr_ovf_cnt", ovf_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_overflow", overflow, 0);
    clear_stats = 1'b1;
    push_ch(1'b0, 8'hEE);
    clear_stats = 1'b0;
    chk("clr_wins_cnt", ovf_cnt, 0);
    chk("clr_wins_flag", overflow, 0);

    // Flush with a simultaneous push.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_full", level, 0);
    for (int i = 0; i < 5; i++) push_ch(1'b0, 8'h60 + 8'(i));
    chk("level5", level, 5);
    flush = 1'b1; din_valid = 1'b1; din = {1'b0, 8'h77};
    step();
    flush = 1'b0; din_valid = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    step();
    chk("flush_push_gone", level, 0);

    // Error counter saturation with discarded characters.
    drop_err = 1'b1; din_valid = 1'b1; din = {1'b1, 8'h00};
    for (int i = 0; i < 260; i++) step();
    din_valid = 1'b0; drop_err = 1'b0;
    chk("err_sat", err_cnt, 255);
    chk("err_sat_level", level, 0);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;

    // Randomised-flow stream against a queue model.
    nxt = 8'hA0; pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 40 || q.size() != 0) && cyc < 2000) begin
      din_valid  = (pushed < 40) && (q.size() < 16) && ($urandom_range(0, 1) == 1);
      din        = {1'b0, nxt};
      dout_ready = ($urandom_range(0, 1) == 1);
      if (dout_ready && q.size() != 0) begin
        chk("stream_valid", dout_valid, 1);
        chk("stream_data", dout, q[0]);
        void'(q.pop_front());
        popped++;
      end
      if (din_valid) begin
        q.push_back(nxt);
        nxt++;
        pushed++;
      end
      step();
      cyc++;
    end
    din_valid = 1'b0; dout_ready = 1'b0;
    chk("stream_count", popped, 40);
    chk("stream_empty", empty, 1);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) push_ch(1'b0, 8'hC0 + 8'(i));
    chk("pre_rst_level", level, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_empty", empty, 1);
    chk("async_level", level, 0);
    chk("async_valid", dout_valid, 0);
    step();
    reset = 1'b1;
    push_ch(1'b0, 8'h5A);
    chk("post_rst_push", level, 1);
    chk("post_rst_data", dout, 8'h5A);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, entry count; SHALL be a power of two, >= 2.
REQ-002 Parameter: UART_DATA_WIDTH, default 8, payload bits per character.
REQ-003 Parameter: CNT_WIDTH, default 8, width of each statistics counter.
REQ-004 Port: clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: din_valid  in  1  character available from the UART receiver.
REQ-007 Port: din_ready  out  1  character accepted this cycle.
REQ-008 Port: din  in  UART_DATA_WIDTH+1  bit [UART_DATA_WIDTH] = parity-error flag; low bits = payload.
REQ-009 Port: drop_err  in  1  1 = discard parity-errored characters; 0 = store them with their flag.
REQ-010 Port: dout_valid  out  1  head entry valid.
REQ-011 Port: dout_ready  in  1  consumer takes the head entry.
REQ-012 Port: dout  out  UART_DATA_WIDTH  head payload.
REQ-013 Port: dout_err  out  1  head entry's parity-error flag.
REQ-014 Port: flush  in  1  synchronous pulse; empties the FIFO.
REQ-015 Port: clear_stats  in  1  synchronous pulse; zeroes overflow, ovf_cnt and err_cnt.
REQ-016 Port: level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 Port: full / empty  out  1 each  level==DEPTH / level==0.
REQ-018 Port: overflow  out  1  sticky; a character was lost to a full FIFO.
REQ-019 Port: ovf_cnt, err_cnt  out  CNT_WIDTH each  saturating counts of overflow drops and parity-errored characters received.

Function
REQ-020 din_ready SHALL be 1 whenever reset is deasserted, so the receiver never stalls; the handshake is din_valid & din_ready.
REQ-021 Push: a handshake with level<DEPTH, not discarded by REQ-023, SHALL write {flag, payload} at the write pointer and advance it.
REQ-022 Overflow: a handshake with level==DEPTH and no pop in the same cycle SHALL drop the character, set overflow, and increment ovf_cnt.
REQ-023 A handshake with flag=1 SHALL increment err_cnt; if drop_err=1 that character SHALL NOT be stored and SHALL NOT count as overflow.
REQ-024 Pop: dout_valid & dout_ready SHALL advance the read pointer.
REQ-025 Simultaneous push and pop SHALL leave level unchanged; when full this push SHALL be accepted, not dropped.
REQ-026 Output is show-ahead: dout_valid = !empty, and dout/dout_err reflect the head entry combinationally from storage.
REQ-027 Latency: a character pushed in cycle N SHALL be visible on dout with dout_valid=1 in cycle N+1 when the FIFO was empty.
REQ-028 Pointers SHALL be log2(DEPTH)+1 bits with modulo-2^(log2(DEPTH)+1) wrap; full and empty SHALL be derived from the pointer MSB and equality.
REQ-029 Counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-030 flush SHALL set both pointers to 0 and takes priority over a push or pop in the same cycle; statistics are unaffected.
REQ-031 clear_stats coinciding with an event SHALL leave the counter and overflow at 0; the clear wins.
REQ-032 Storage contents SHALL NOT need reset; only pointers, flags and counters are reset.

Reset
REQ-033 While reset is low: level=0, empty=1, full=0, dout_valid=0, overflow=0, ovf_cnt=0, err_cnt=0, din_ready=0.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously.
REQ-035 After reset deasserts, the first clock edge SHALL accept pushes.

Verification
REQ-036 Push 0x41, 0x42, 0x43 with dout_ready=0 -> level=3; raise dout_ready -> outputs 0x41, 0x42, 0x43 on consecutive cycles, then empty=1.
REQ-037 DEPTH=16: push 17 characters, no pop -> full=1, overflow=1, ovf_cnt=1, 17th character absent; then push and pop in the same cycle -> accepted, level stays 16.
REQ-038 drop_err=1, push {1,0x55} -> err_cnt=1, level=0; drop_err=0, same push -> err_cnt=2, dout=0x55, dout_err=1.
REQ-039 Stream 40 characters through with random dout_ready -> pointer wrap is exercised; output order and data match the input exactly.
REQ-040 Flush at level=5 while pushing -> level=0 next cycle, push discarded; clear_stats with ovf_cnt=3 -> 0; reset pulse mid-stream -> empty=1 asynchronously.
